pipe_feed_fifo: RTL and testbench

Buffered input stage that sits directly upstream of the `pipe_pal` datapath and feeds its `W_DATA`-wide operand. It decouples the producer from the pipeline with a small synchronous FIFO and valid/ready handshakes on both sides. It also keeps a wrapping count of words delivered downstream. The block has no combinational path from `m_ready` to `s_ready` and no path from `s_valid` to `m_valid`.

---
 rtl/pipe_feed_fifo.sv | 86 ++++++++
 tb/tb_pipe_feed_fifo.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_feed_fifo.sv
// Buffered input stage for the pipe_pal datapath. A small register-array FIFO
// sits between two valid/ready handshakes and counts the words it delivers.
module pipe_feed_fifo #(
  parameter  int W_DATA = 32,
  parameter  int DEPTH  = 4,
  localparam int W_ADDR = 16,
  localparam int W_CNT  = $clog2(DEPTH) + 1
) (
  input  logic              i_clk,
  input  logic              resetn,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [W_DATA-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [W_DATA-1:0] m_data,
  output logic [W_CNT-1:0]  o_count,
  output logic [W_ADDR-1:0] o_xfer_cnt
);

  localparam int W_PTR = $clog2(DEPTH);

  logic [W_DATA-1:0] r_mem [DEPTH];
  logic [W_PTR-1:0]  r_wr_ptr;
  logic [W_PTR-1:0]  r_rd_ptr;
  logic [W_CNT-1:0]  r_count;
  logic [W_ADDR-1:0] r_xfer_cnt;

  logic              w_push;
  logic              w_pop;
  logic [W_CNT-1:0]  w_count_nxt;

  // Both handshake flags come from registered occupancy only, so there is no
  // combinational path from m_ready to s_ready or from s_valid to m_valid.
  assign s_ready    = (r_count != W_CNT'(DEPTH));
  assign m_valid    = (r_count != '0);
  assign w_push     = s_valid && s_ready;
  assign w_pop      = m_valid && m_ready;
  assign m_data     = r_mem[r_rd_ptr];
  assign o_count    = r_count;
  assign o_xfer_cnt = r_xfer_cnt;

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + 1'b1;
      2'b01:   w_count_nxt = r_count - 1'b1;
      default: w_count_nxt = r_count;
    endcase
  end

  // NOTE: the storage array is reset along with the pointers because m_data
  // must read as zero straight out of reset, not as whatever powered up.
  always_ff @(posedge i_clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_push) begin
      r_mem[r_wr_ptr] <= s_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge i_clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_xfer_cnt <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr   <= r_rd_ptr + 1'b1;
        r_xfer_cnt <= r_xfer_cnt + 1'b1;
      end
      r_count <= w_count_nxt;
    end
  end

endmodule

// File: tb/tb_pipe_feed_fifo.sv
// Self-checking bench for pipe_feed_fifo: directed vector table, a queue
// model for random and long streams, and an asynchronous reset probe.
module tb_pipe_feed_fifo;

  localparam int W_DATA = 32;
  localparam int DEPTH  = 4;

  logic              i_clk;
  logic              resetn;
  logic              s_valid;
  logic              s_ready;
  logic [W_DATA-1:0] s_data;
  logic              m_valid;
  logic              m_ready;
  logic [W_DATA-1:0] m_data;
  logic [2:0]        o_count;
  logic [15:0]       o_xfer_cnt;

  pipe_feed_fifo #(.W_DATA(W_DATA), .DEPTH(DEPTH)) dut (
    .i_clk      (i_clk),
    .resetn     (resetn),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .o_count    (o_count),
    .o_xfer_cnt (o_xfer_cnt)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // One row: outputs expected at this cycle's negedge, then inputs driven
  // for the following rising edge.
  typedef struct {
    logic        sv;
    logic [31:0] sd;
    logic        mr;
    logic        e_sr;
    logic        e_mv;
    logic        md_chk;
    logic [31:0] e_md;
    logic [2:0]  e_cnt;
    logic [15:0] e_xfer;
  } vec_t;

  vec_t        vecs [14];
  int          n_checks;
  int          n_errors;
  int          n_pops;
  logic [31:0] q [$];
  logic [15:0] m_xfer;
  logic        hold_valid;
  logic [31:0] hold_data;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    q.delete();
    m_xfer     = '0;
    hold_valid = 1'b0;
    hold_data  = '0;
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    resetn  = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    m_ready = 1'b0;
    model_clear();
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    resetn = 1'b1;
  endtask

  // Checks the DUT against the queue model at the negedge, then drives the
  // next inputs and advances the model by the handshakes the model predicts.
  task automatic model_cycle(input logic sv, input logic [31:0] sd, input logic mr);
    logic e_sr;
    logic e_mv;
    @(negedge i_clk);
    e_sr = (q.size() != DEPTH);
    e_mv = (q.size() != 0);
    check("s_ready", s_ready, e_sr);
    check("m_valid", m_valid, e_mv);
    check("o_count", o_count, q.size());
    check("o_xfer_cnt", o_xfer_cnt, m_xfer);
    if (e_mv) check("m_data_order", m_data, q[0]);
    if (hold_valid) check("m_data_hold", m_data, hold_data);
    s_valid    = sv;
    s_data     = sd;
    m_ready    = mr;
    hold_valid = e_mv && !mr;
    hold_data  = m_data;
    if (e_mv && mr) begin
      void'(q.pop_front());
      m_xfer = m_xfer + 16'd1;
      n_pops++;
    end
    if (sv && e_sr) q.push_back(sd);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    n_pops   = 0;
    model_clear();
    resetn  = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    m_ready = 1'b0;

    //                sv    sd            mr    sr    mv    mdc   md            cnt   xfer
    vecs[0]  = '{1'b1, 32'h0000_00A0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0,        3'd0, 16'd0};
    vecs[1]  = '{1'b1, 32'h0000_00A1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_00A0, 3'd1, 16'd0};
    vecs[2]  = '{1'b1, 32'h0000_00A2, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_00A0, 3'd2, 16'd0};
    vecs[3]  = '{1'b1, 32'h0000_00A3, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_00A0, 3'd3, 16'd0};
    vecs[4]  = '{1'b1, 32'h0000_00A4, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_00A0, 3'd4, 16'd0};
    vecs[5]  = '{1'b1, 32'h0000_00A4, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_00A0, 3'd4, 16'd0};
    vecs[6]  = '{1'b1, 32'h0000_00A4, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_00A1, 3'd3, 16'd1};
    vecs[7]  = '{1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_00A2, 3'd3, 16'd2};
    vecs[8]  = '{1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_00A3, 3'd2, 16'd3};
    vecs[9]  = '{1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_00A4, 3'd1, 16'd4};
    vecs[10] = '{1'b1, 32'h0000_0055, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,        3'd0, 16'd5};
    vecs[11] = '{1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0055, 3'd1, 16'd5};
    vecs[12] = '{1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0055, 3'd1, 16'd5};
    vecs[13] = '{1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        3'd0, 16'd6};

    // Outputs while reset is held, then ten idle cycles after release.
    #3;
    check("rst_s_ready", s_ready, 1'b1);
    check("rst_m_valid", m_valid, 1'b0);
    check("rst_m_data", m_data, 32'h0);
    check("rst_o_count", o_count, 3'd0);
    check("rst_o_xfer_cnt", o_xfer_cnt, 16'd0);
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    resetn = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge i_clk);
      check("idle_s_ready", s_ready, 1'b1);
      check("idle_m_valid", m_valid, 1'b0);
      check("idle_m_data", m_data, 32'h0);
      check("idle_o_count", o_count, 3'd0);
      check("idle_o_xfer_cnt", o_xfer_cnt, 16'd0);
    end

    // Fill to full, push held off, pop-at-full, drain, push into empty.
    for (int i = 0; i < 14; i++) begin
      @(negedge i_clk);
      check($sformatf("vec%0d_s_ready", i), s_ready, vecs[i].e_sr);
      check($sformatf("vec%0d_m_valid", i), m_valid, vecs[i].e_mv);
      check($sformatf("vec%0d_o_count", i), o_count, vecs[i].e_cnt);
      check($sformatf("vec%0d_o_xfer_cnt", i), o_xfer_cnt, vecs[i].e_xfer);
      if (vecs[i].md_chk) check($sformatf("vec%0d_m_data", i), m_data, vecs[i].e_md);
      s_valid = vecs[i].sv;
      s_data  = vecs[i].sd;
      m_ready = vecs[i].mr;
    end

    // Random traffic with 50% valid/ready on both sides.
    do_reset();
    n_pops = 0;
    for (int c = 0; c < 20000 && n_pops < 1000; c++) begin
      model_cycle(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
    end
    check("random_pop_budget", n_pops, 1000);

    // Sustained streaming until the 16-bit delivered-word counter wraps.
    do_reset();
    n_pops = 0;
    for (int c = 0; c < 70000 && n_pops < 65537; c++) begin
      model_cycle(1'b1, 32'(c), 1'b1);
    end
    check("wrap_pop_budget", n_pops, 65537);
    model_cycle(1'b0, 32'h0, 1'b0);
    check("xfer_wrap", o_xfer_cnt, 16'd1);

    // Build up to three stored words, then reset between clock edges.
    model_cycle(1'b1, 32'h0000_0B01, 1'b0);
    model_cycle(1'b1, 32'h0000_0B02, 1'b0);
    model_cycle(1'b0, 32'h0, 1'b0);
    check("pre_reset_count", o_count, 3'd3);
    @(posedge i_clk);
    #2;
    resetn = 1'b0;
    #1;
    check("async_o_count", o_count, 3'd0);
    check("async_m_valid", m_valid, 1'b0);
    check("async_s_ready", s_ready, 1'b1);
    check("async_o_xfer_cnt", o_xfer_cnt, 16'd0);
    check("async_m_data", m_data, 32'h0);
    @(negedge i_clk);
    resetn = 1'b1;
    model_clear();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
